// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: assembles 5-byte command frames from the UART RX byte
// stream, runs register writes/reads on an 8-bit register bus and returns a
// 5-byte response frame on the UART TX byte stream.
module uart_cmd_parser #(
  parameter int RD_LATENCY     = 1,
  parameter int TIMEOUT_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  from_uart_data,
  input  logic        from_uart_valid,
  input  logic        from_uart_error,
  output logic        from_uart_ready,
  output logic [7:0]  to_uart_data,
  output logic        to_uart_valid,
  output logic        to_uart_error,
  input  logic        to_uart_ready,
  output logic [7:0]  reg_addr,
  output logic [7:0]  reg_wdata,
  output logic        reg_wr,
  output logic        reg_rd,
  input  logic [7:0]  reg_rdata,
  output logic [15:0] frame_err_cnt
);

  // Handshake (both byte streams): a byte transfers at a rising edge where
  // valid and ready are both 1; the producer holds data stable until then.

  localparam logic [7:0]  SOF_CMD    = 8'hA5;
  localparam logic [7:0]  SOF_RSP    = 8'h5A;
  localparam logic [7:0]  CMD_WR     = 8'h01;
  localparam logic [7:0]  CMD_RD     = 8'h02;
  localparam logic [7:0]  ST_OK      = 8'h00;
  localparam logic [7:0]  ST_BAD_CHK = 8'h01;
  localparam logic [7:0]  ST_BAD_CMD = 8'h02;
  localparam logic [23:0] TMO_LAST   = 24'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]  RD_LAST    = 3'(RD_LATENCY - 1);

  typedef enum logic [2:0] {
    S_HUNT, S_GET_CMD, S_GET_ADDR, S_GET_DATA, S_GET_CHK, S_EXEC, S_WAIT_RD, S_RESP
  } state_t;

  state_t      state, next_state;
  logic        ready_en;
  logic        in_rx, in_frame;
  logic        accept, ok_accept, err_accept, timeout, chk_ok, inc_err;
  logic [23:0] tmo_cnt;
  logic [2:0]  wait_cnt, byte_idx;
  logic [7:0]  cmd_q, addr_q, data_q, status_q, rsp_data_q;

  assign in_rx      = (state inside {S_HUNT, S_GET_CMD, S_GET_ADDR, S_GET_DATA, S_GET_CHK});
  assign in_frame   = (state inside {S_GET_CMD, S_GET_ADDR, S_GET_DATA, S_GET_CHK});
  assign accept     = from_uart_valid & from_uart_ready;
  assign ok_accept  = accept & ~from_uart_error;
  assign err_accept = accept & from_uart_error;
  // An accepted byte clears the idle counter, so a timeout never coincides with an error byte.
  assign timeout    = in_frame & ~accept & (tmo_cnt == TMO_LAST);
  assign chk_ok     = ((cmd_q ^ addr_q ^ data_q) == from_uart_data);
  assign inc_err    = err_accept | timeout | ((state == S_EXEC) & (status_q != ST_OK));
  assign to_uart_error = 1'b0;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_HUNT;
    else        state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      S_HUNT:     if (ok_accept && from_uart_data == SOF_CMD) next_state = S_GET_CMD;
      S_GET_CMD:  if (err_accept || timeout) next_state = S_HUNT;
                  else if (ok_accept)        next_state = S_GET_ADDR;
      S_GET_ADDR: if (err_accept || timeout) next_state = S_HUNT;
                  else if (ok_accept)        next_state = S_GET_DATA;
      S_GET_DATA: if (err_accept || timeout) next_state = S_HUNT;
                  else if (ok_accept)        next_state = S_GET_CHK;
      S_GET_CHK:  if (err_accept || timeout) next_state = S_HUNT;
                  else if (ok_accept)        next_state = S_EXEC;
      S_EXEC:     next_state = (status_q == ST_OK && cmd_q == CMD_RD) ? S_WAIT_RD : S_RESP;
      S_WAIT_RD:  if (wait_cnt == RD_LAST) next_state = S_RESP;
      S_RESP:     if (to_uart_ready && byte_idx == 3'd4) next_state = S_HUNT;
      default:    next_state = S_HUNT;
    endcase
  end

  // Outputs decoded from state; strobes are high for the single EXEC cycle.
  always_comb begin
    from_uart_ready = ready_en & in_rx;
    to_uart_valid   = (state == S_RESP);
    to_uart_data    = 8'h00;
    if (state == S_RESP) begin
      case (byte_idx)
        3'd0:    to_uart_data = SOF_RSP;
        3'd1:    to_uart_data = status_q;
        3'd2:    to_uart_data = addr_q;
        3'd3:    to_uart_data = rsp_data_q;
        default: to_uart_data = status_q ^ addr_q ^ rsp_data_q;
      endcase
    end
    reg_wr = (state == S_EXEC) && (status_q == ST_OK) && (cmd_q == CMD_WR);
    reg_rd = (state == S_EXEC) && (status_q == ST_OK) && (cmd_q == CMD_RD);
  end

  // Sequencing counters: RX enable after reset, inter-byte timeout, read wait, response byte index.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_en <= 1'b0;
      tmo_cnt  <= '0;
      wait_cnt <= '0;
      byte_idx <= '0;
    end else begin
      ready_en <= 1'b1;
      if (!in_frame || accept) tmo_cnt <= '0;
      else                     tmo_cnt <= tmo_cnt + 24'd1;
      if (state == S_WAIT_RD) wait_cnt <= wait_cnt + 3'd1;
      else                    wait_cnt <= '0;
      if (state != S_RESP)    byte_idx <= '0;
      else if (to_uart_ready) byte_idx <= byte_idx + 3'd1;
    end
  end

  // Frame capture, status/response data and the register-bus address/data holding registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      status_q   <= '0;
      rsp_data_q <= '0;
      reg_addr   <= '0;
      reg_wdata  <= '0;
    end else begin
      if (ok_accept && state == S_GET_CMD)  cmd_q  <= from_uart_data;
      if (ok_accept && state == S_GET_ADDR) addr_q <= from_uart_data;
      if (ok_accept && state == S_GET_DATA) data_q <= from_uart_data;
      if (ok_accept && state == S_GET_CHK) begin
        // Checksum is judged before the command code.
        if (!chk_ok)                                 status_q <= ST_BAD_CHK;
        else if (cmd_q != CMD_WR && cmd_q != CMD_RD) status_q <= ST_BAD_CMD;
        else                                         status_q <= ST_OK;
        rsp_data_q <= (chk_ok && cmd_q == CMD_WR) ? data_q : 8'h00;
        if (chk_ok && (cmd_q == CMD_WR || cmd_q == CMD_RD)) reg_addr  <= addr_q;
        if (chk_ok && cmd_q == CMD_WR)                      reg_wdata <= data_q;
      end
      if (state == S_WAIT_RD && wait_cnt == RD_LAST) rsp_data_q <= reg_rdata;
    end
  end

  // Saturating frame error counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                   frame_err_cnt <= '0;
    else if (inc_err && frame_err_cnt != 16'hFFFF) frame_err_cnt <= frame_err_cnt + 16'd1;
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb_uart_cmd_parser: directed plan frames plus randomized frames against a
// frame-level reference model and a behavioural register-bus slave.
`timescale 1ns/1ps
module tb_uart_cmd_parser;

  localparam int RD_LAT = 1;
  localparam int TMO    = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  from_uart_data;
  logic        from_uart_valid, from_uart_error, from_uart_ready;
  logic [7:0]  to_uart_data;
  logic        to_uart_valid, to_uart_error, to_uart_ready;
  logic [7:0]  reg_addr, reg_wdata, reg_rdata;
  logic        reg_wr, reg_rd;
  logic [15:0] frame_err_cnt;

  uart_cmd_parser #(.RD_LATENCY(RD_LAT), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .from_uart_data(from_uart_data), .from_uart_valid(from_uart_valid),
    .from_uart_error(from_uart_error), .from_uart_ready(from_uart_ready),
    .to_uart_data(to_uart_data), .to_uart_valid(to_uart_valid),
    .to_uart_error(to_uart_error), .to_uart_ready(to_uart_ready),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wr(reg_wr), .reg_rd(reg_rd),
    .reg_rdata(reg_rdata), .frame_err_cnt(frame_err_cnt)
  );

  // ---------------- bench state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int cyc = 0, rise_cyc = 0, last_hs_cyc = 0, chk_cyc = 0;
  int wr_cnt = 0, rd_cnt = 0, wr_cyc = 0, rd_cyc = 0;
  int exp_err = 0;
  logic prev_v = 1'b0;
  logic [7:0] last_wr_addr, last_wr_data, last_rd_addr;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] bus_mem [0:255];
  logic [7:0] ref_mem [0:255];
  logic       rd_v [1:RD_LAT];
  logic [7:0] rd_a [1:RD_LAT];

  // Register slave: read data appears RD_LAT cycles after the strobe cycle, junk otherwise.
  assign reg_rdata = rd_v[RD_LAT] ? bus_mem[rd_a[RD_LAT]] : 8'hEE;

  // Cycle counter, TX monitor and register-bus slave.
  always @(posedge clk) begin
    cyc    <= cyc + 1;
    prev_v <= to_uart_valid;
    if (to_uart_valid && !prev_v) rise_cyc <= cyc;
    if (to_uart_valid && to_uart_ready) begin
      got_q.push_back(to_uart_data);
      last_hs_cyc <= cyc;
    end
    if (reg_wr) begin
      wr_cnt <= wr_cnt + 1;
      wr_cyc <= cyc;
      last_wr_addr <= reg_addr;
      last_wr_data <= reg_wdata;
      bus_mem[reg_addr] <= reg_wdata;
    end
    if (reg_rd) begin
      rd_cnt <= rd_cnt + 1;
      rd_cyc <= cyc;
      last_rd_addr <= reg_addr;
    end
    rd_v[1] <= reg_rd;
    rd_a[1] <= reg_addr;
    for (int k = RD_LAT; k >= 2; k--) begin
      rd_v[k] <= rd_v[k-1];
      rd_a[k] <= rd_a[k-1];
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: status, response bytes and register effect of one complete frame.
  function automatic void model_frame(input logic [7:0] cmd, input logic [7:0] addr,
                                      input logic [7:0] data, input logic [7:0] chk,
                                      output int wr_ok, output int rd_ok);
    logic [7:0] st, d;
    if ((cmd ^ addr ^ data) != chk)        st = 8'h01;
    else if (cmd != 8'h01 && cmd != 8'h02) st = 8'h02;
    else                                   st = 8'h00;
    wr_ok = (st == 8'h00 && cmd == 8'h01) ? 1 : 0;
    rd_ok = (st == 8'h00 && cmd == 8'h02) ? 1 : 0;
    if (st != 8'h00) d = 8'h00;
    else if (wr_ok == 1) d = data;
    else d = ref_mem[addr];
    if (wr_ok == 1) ref_mem[addr] = data;
    if (st != 8'h00 && exp_err < 65535) exp_err++;
    exp_q.push_back(8'h5A);
    exp_q.push_back(st);
    exp_q.push_back(addr);
    exp_q.push_back(d);
    exp_q.push_back(st ^ addr ^ d);
  endfunction

  // ---------------- drivers ----------------
  task automatic send_byte(input logic [7:0] b, input logic e);
    int n = 0;
    @(negedge clk);
    from_uart_data  = b;
    from_uart_error = e;
    from_uart_valid = 1'b1;
    while (!from_uart_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!from_uart_ready) check("rx_accept_timeout", 0, 1);
    else begin
      @(posedge clk);
      chk_cyc = cyc;
    end
    #1;
    from_uart_valid = 1'b0;
    from_uart_error = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [7:0] addr,
                            input logic [7:0] data, input logic [7:0] chk);
    send_byte(8'hA5, 1'b0);
    send_byte(cmd, 1'b0);
    send_byte(addr, 1'b0);
    send_byte(data, 1'b0);
    send_byte(chk, 1'b0);
  endtask

  // Wait (bounded) until n response bytes were seen; optionally randomize TX ready.
  task automatic wait_got(input int n, input bit rand_bp);
    int k = 0;
    @(negedge clk);
    while (got_q.size() < n && k < 400) begin
      to_uart_ready = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      k++;
    end
    to_uart_ready = 1'b1;
    if (got_q.size() < n) check("rsp_wait_timeout", got_q.size(), n);
  endtask

  task automatic compare_rsp(input string tag);
    check({tag, "_len"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0)
      check({tag, "_byte"}, got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
  endtask

  // One full command/response exchange with latency, strobe and counter checks.
  task automatic run_frame(input string tag, input logic [7:0] cmd, input logic [7:0] addr,
                           input logic [7:0] data, input logic [7:0] chk, input bit rand_bp);
    int wr_ok, rd_ok, w0, r0;
    w0 = wr_cnt;
    r0 = rd_cnt;
    model_frame(cmd, addr, data, chk, wr_ok, rd_ok);
    send_frame(cmd, addr, data, chk);
    wait_got(5, rand_bp);
    check({tag, "_latency"}, rise_cyc - chk_cyc, (rd_ok == 1) ? 2 + RD_LAT : 2);
    if (!rand_bp) begin
      check({tag, "_burst"}, last_hs_cyc - rise_cyc, 4);
      check({tag, "_hunt_ready"}, from_uart_ready, 1);
    end
    compare_rsp(tag);
    check({tag, "_wr_cnt"}, wr_cnt - w0, wr_ok);
    check({tag, "_rd_cnt"}, rd_cnt - r0, rd_ok);
    if (wr_ok == 1) begin
      check({tag, "_wr_addr"}, last_wr_addr, addr);
      check({tag, "_wr_data"}, last_wr_data, data);
      check({tag, "_wr_cyc"}, wr_cyc - chk_cyc, 1);
    end
    if (rd_ok == 1) begin
      check({tag, "_rd_addr"}, last_rd_addr, addr);
      check({tag, "_rd_cyc"}, rd_cyc - chk_cyc, 1);
    end
    check({tag, "_err_cnt"}, frame_err_cnt, exp_err);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] a, d, c, x;
    int kind, mism;
    from_uart_data  = 8'h00;
    from_uart_valid = 1'b0;
    from_uart_error = 1'b0;
    to_uart_ready   = 1'b1;
    for (int i = 0; i < 256; i++) begin
      x = 8'($urandom_range(0, 255));
      bus_mem[i] = x;
      ref_mem[i] = x;
    end

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_from_ready", from_uart_ready, 0);
    check("rst_to_valid", to_uart_valid, 0);
    check("rst_to_data", to_uart_data, 0);
    check("rst_to_error", to_uart_error, 0);
    check("rst_strobes", {reg_wr, reg_rd}, 0);
    check("rst_reg_addr", reg_addr, 0);
    check("rst_reg_wdata", reg_wdata, 0);
    check("rst_err_cnt", frame_err_cnt, 0);
    reset = 1'b1;
    #1;
    check("rst_ready_before_clk", from_uart_ready, 0);
    @(posedge clk);
    #1;
    check("rst_ready_after_clk", from_uart_ready, 1);

    // Plan frames: write, read (0x7E at 0x20), bad checksum, bad command.
    run_frame("write", 8'h01, 8'h10, 8'h3C, 8'h2D, 1'b0);
    bus_mem[8'h20] = 8'h7E;
    ref_mem[8'h20] = 8'h7E;
    run_frame("read", 8'h02, 8'h20, 8'h00, 8'h22, 1'b0);
    run_frame("bad_chk", 8'h01, 8'h10, 8'h3C, 8'h00, 1'b0);
    run_frame("bad_cmd", 8'h07, 8'h10, 8'h3C, 8'h2B, 1'b0);
    check("bad_cmd_total_err", frame_err_cnt, 2);

    // Resync: junk byte dropped silently, partial frame times out.
    send_byte(8'h33, 1'b0);
    send_byte(8'hA5, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h10, 1'b0);
    repeat (TMO - 2) @(negedge clk);
    check("tmo_early", frame_err_cnt, exp_err);
    repeat (5) @(negedge clk);
    exp_err++;
    check("tmo_count", frame_err_cnt, exp_err);
    check("tmo_no_rsp", got_q.size(), 0);
    check("tmo_hunt_ready", from_uart_ready, 1);

    // Errored 0xA5 is dropped and counted; the next frame is still parsed.
    send_byte(8'hA5, 1'b1);
    repeat (2) @(negedge clk);
    exp_err++;
    check("err_a5_count", frame_err_cnt, exp_err);
    check("err_a5_no_rsp", got_q.size(), 0);
    run_frame("after_err", 8'h01, 8'h44, 8'h99, 8'h01 ^ 8'h44 ^ 8'h99, 1'b0);

    // Backpressure on response byte 2.
    begin
      int wr_ok, rd_ok;
      model_frame(8'h01, 8'h10, 8'h3C, 8'h2D, wr_ok, rd_ok);
      send_frame(8'h01, 8'h10, 8'h3C, 8'h2D);
      wait_got(2, 1'b0);
      to_uart_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        check("bp_data_hold", to_uart_data, 8'h10);
        check("bp_valid_hold", to_uart_valid, 1);
        check("bp_rx_blocked", from_uart_ready, 0);
      end
      to_uart_ready = 1'b1;
      wait_got(5, 1'b0);
      compare_rsp("bp");
    end

    // Reset in the middle of a response.
    begin
      int wr_ok, rd_ok;
      model_frame(8'h01, 8'h55, 8'h66, 8'h01 ^ 8'h55 ^ 8'h66, wr_ok, rd_ok);
      exp_err = exp_err + 1;  // frame_err_cnt is non-zero before the reset
      send_frame(8'h01, 8'h55, 8'h66, 8'h01 ^ 8'h55 ^ 8'h66);
      wait_got(2, 1'b0);
      reset = 1'b0;
      #1;
      check("mid_rst_to_valid", to_uart_valid, 0);
      check("mid_rst_to_data", to_uart_data, 0);
      check("mid_rst_from_ready", from_uart_ready, 0);
      check("mid_rst_strobes", {reg_wr, reg_rd}, 0);
      check("mid_rst_reg_addr", reg_addr, 0);
      check("mid_rst_reg_wdata", reg_wdata, 0);
      check("mid_rst_err_cnt", frame_err_cnt, 0);
      exp_err = 0;
      repeat (2) @(negedge clk);
      got_q.delete();
      exp_q.delete();
      reset = 1'b1;
      run_frame("post_rst", 8'h01, 8'h77, 8'h12, 8'h01 ^ 8'h77 ^ 8'h12, 1'b0);
    end

    // Randomized frames with random TX backpressure.
    for (int i = 0; i < 24; i++) begin
      kind = $urandom_range(0, 4);
      a = 8'($urandom_range(0, 255));
      d = 8'($urandom_range(0, 255));
      case (kind)
        0: run_frame("rnd_wr", 8'h01, a, d, 8'h01 ^ a ^ d, 1'b1);
        1: run_frame("rnd_rd", 8'h02, a, d, 8'h02 ^ a ^ d, 1'b1);
        2: begin
          c = 8'($urandom_range(1, 2));
          x = 8'($urandom_range(1, 255));
          run_frame("rnd_badchk", c, a, d, c ^ a ^ d ^ x, 1'b1);
        end
        3: begin
          c = 8'($urandom_range(3, 255));
          run_frame("rnd_badcmd", c, a, d, c ^ a ^ d, 1'b1);
        end
        default: begin
          send_byte(8'hA5, 1'b0);
          for (int k = 0; k < int'($urandom_range(0, 2)); k++) send_byte(8'($urandom_range(0, 255)), 1'b0);
          send_byte(8'($urandom_range(0, 255)), 1'b1);
          repeat (4) @(negedge clk);
          exp_err++;
          check("rnd_abort_err", frame_err_cnt, exp_err);
          check("rnd_abort_no_rsp", got_q.size(), 0);
        end
      endcase
    end

    // Register image seen by the bus slave must match the model.
    mism = 0;
    for (int i = 0; i < 256; i++) if (bus_mem[i] !== ref_mem[i]) mism++;
    check("mem_image", mism, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_cmd_parser.md
# uart_cmd_parser

Byte-level command engine sitting directly downstream of the UART MCU core. It consumes the received byte stream (`from_uart_*`), assembles fixed 5-byte command frames, and executes register writes/reads on a simple 8-bit register bus. It returns a 5-byte response frame into the UART transmit stream (`to_uart_*`). It provides host register access over the UART link.

## Interface
Parameters:
- `RD_LATENCY`, 1: cycles from `reg_rd` assertion to valid `reg_rdata` (1..4).
- `TIMEOUT_CYCLES`, 500000: inter-byte timeout inside a frame (10 ms at 50 MHz), range 2..2^24-1.

Ports:
- `clk` input 1: system clock.
- `reset` input 1: asynchronous, active-low reset.
- `from_uart_data` input 8: received byte.
- `from_uart_valid` input 1: received byte valid.
- `from_uart_error` input 1: received byte has framing/parity error.
- `from_uart_ready` output 1: parser accepts byte.
- `to_uart_data` output 8: response byte.
- `to_uart_valid` output 1: response byte valid.
- `to_uart_error` output 1: constant 0.
- `to_uart_ready` input 1: UART TX accepts byte.
- `reg_addr` output 8: register address.
- `reg_wdata` output 8: write data.
- `reg_wr` output 1: one-cycle write strobe.
- `reg_rd` output 1: one-cycle read strobe.
- `reg_rdata` input 8: read data.
- `frame_err_cnt` output 16: saturating error counter.

## Operation
- Command frame: `0xA5`, CMD, ADDR, DATA, CHK. CHK = CMD^ADDR^DATA. CMD `0x01` is write and `0x02` is read. DATA is ignored for read but must be present.
- Response frame: `0x5A`, STATUS, ADDR, DATA, CHK. CHK = STATUS^ADDR^DATA.
- STATUS values: `0x00` OK, `0x01` bad checksum, `0x02` bad CMD.
- Response DATA is the echoed write data, the read data, or `0x00` on any error.
- States: HUNT, GET_CMD, GET_ADDR, GET_DATA, GET_CHK, EXEC, WAIT_RD, RESP.
- A byte is accepted on `from_uart_valid & from_uart_ready`.
- `from_uart_ready` = 1 in HUNT..GET_CHK and 0 in EXEC/WAIT_RD/RESP.
- HUNT: `0xA5` goes to GET_CMD. Any other byte is dropped silently with no count.
- Any accepted byte with `from_uart_error`=1, in any receive state: byte dropped, `frame_err_cnt`++, go to HUNT. This includes a `0xA5` value.
- Timeout: in GET_CMD..GET_CHK, the counter clears on each accepted byte and increments otherwise. When it reaches TIMEOUT_CYCLES: go to HUNT, `frame_err_cnt`++.
- After GET_CHK the FSM moves to EXEC.
  - Bad checksum: STATUS=`0x01`, no strobe, `frame_err_cnt`++.
  - Good checksum, unknown CMD: STATUS=`0x02`, no strobe, `frame_err_cnt`++.
  - Write: `reg_wr`=1 for one cycle with `reg_addr`/`reg_wdata`.
  - Read: `reg_rd`=1 for one cycle, then WAIT_RD for RD_LATENCY cycles. `reg_rdata` is captured on the last WAIT_RD edge.
- Checksum takes priority over CMD check.
- RESP: sends 5 bytes in order. Each byte is held stable while `to_uart_valid & !to_uart_ready`, and advances on a handshake. After byte 4 is accepted, go to HUNT.
- `frame_err_cnt` saturates at `0xFFFF`.
- `reg_addr`/`reg_wdata` hold their last values between strobes.

## Timing
- Reset (`reset`=0, async):
  - State HUNT.
  - `from_uart_ready`, `to_uart_valid`, `to_uart_data`, `to_uart_error`, `reg_wr`, `reg_rd`, `reg_addr`, `reg_wdata` = 0.
  - `frame_err_cnt` = 0.
  - `from_uart_ready` rises the first clock after reset deasserts.
- CHK byte accepted in cycle N: EXEC is cycle N+1, and strobes are high in N+1.
- First response byte:
  - Write or error: `to_uart_valid` rises in cycle N+2.
  - Read: `to_uart_valid` rises in cycle N+2+RD_LATENCY.
- With `to_uart_ready` held 1, the response occupies exactly 5 consecutive cycles. HUNT with `from_uart_ready`=1 follows in the next cycle.
- Bytes offered while `from_uart_ready`=0 are not consumed; upstream holds them.
- Reset asserted mid-frame or mid-response: immediate return to reset values, partial frame/response discarded, no strobe issued.
- Timeout and error byte in the same cycle: counted once.

## Test plan
- Write: send A5 01 10 3C 2D. Expect `reg_wr` pulse with addr `0x10`, data `0x3C`, then response 5A 00 10 3C 2C with `to_uart_valid` at N+2.
- Read with RD_LATENCY=1 and `reg_rdata`=`0x7E`: send A5 02 20 00 22. Expect one `reg_rd` pulse with addr `0x20`, then response 5A 00 20 7E 5E starting at N+3.
- Bad checksum and bad CMD:
  - A5 01 10 3C 00 gives 5A 01 10 00 11, no `reg_wr`, `frame_err_cnt`=1.
  - A5 07 10 3C 2B gives 5A 02 10 00 12, `frame_err_cnt`=2.
- Resync and error: send 33 A5 01 10, then wait TIMEOUT_CYCLES (set 16) idle. Expect HUNT, `frame_err_cnt`+1, no response. Then A5 with `from_uart_error`=1 is dropped with count+1, and a following valid write frame succeeds.
- Backpressure: hold `to_uart_ready`=0 for 10 cycles during response byte 2. `to_uart_data` stays `0x10`, `from_uart_ready` stays 0, and bytes continue correctly after release.
- Reset mid-response: assert `reset`=0 after byte 1 is sent. All outputs go to 0 immediately. After release, a new write frame gets a full correct response.
